// File: rtl/encoder_scanner_if.sv
// Host-side bus of the quadrature encoder scanner: read/clear handshakes,
// readiness and the currently serviced channel.
interface encoder_scanner_if #(
    parameter int NCH   = 4,
    parameter int POS_W = 8
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic             rd_req;
    logic [CH_W-1:0]  rd_ch;
    logic             rd_ack;
    logic [POS_W-1:0] rd_pos;
    logic             rd_err;
    logic             clr_req;
    logic [CH_W-1:0]  clr_ch;
    logic             clr_ack;
    logic             ready;
    logic [CH_W-1:0]  scan_ch;

    modport master (
        output rd_req, rd_ch, clr_req, clr_ch,
        input  rd_ack, rd_pos, rd_err, clr_ack, ready, scan_ch
    );

    modport slave (
        input  rd_req, rd_ch, clr_req, clr_ch,
        output rd_ack, rd_pos, rd_err, clr_ack, ready, scan_ch
    );
endinterface

// File: rtl/encoder_scanner.sv
// Round-robin quadrature decoder: one shared decoder services NCH encoder
// channels, keeping a wrapping position and a sticky error bit per channel.
module encoder_scanner #(
    parameter int NCH   = 4,
    parameter int POS_W = 8
) (
    input  logic           sysclk,
    input  logic           reset,
    input  logic [NCH-1:0] enc_a_raw,
    input  logic [NCH-1:0] enc_b_raw,
    encoder_scanner_if.slave host
);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNT_W = $clog2(NCH + 2);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_ACK  = 1'b1;

    logic [NCH-1:0]   a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [CH_W-1:0]  scan_ch_q, scan_ch_d;
    logic [0:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic [0:0]       rd_state_q, rd_state_d;
    logic [POS_W-1:0] rd_pos_q, rd_pos_d;
    logic             rd_err_q, rd_err_d;
    logic             clr_ack_q, clr_ack_d;

    logic [POS_W-1:0] pos_q  [NCH];
    logic [POS_W-1:0] pos_d  [NCH];
    logic             err_q  [NCH];
    logic             err_d  [NCH];
    logic [1:0]       last_q [NCH];
    logic [1:0]       last_d [NCH];

    logic       ready;
    logic       rd_fire;
    logic       clr_fire;
    logic [1:0] svc_cur;
    logic [1:0] svc_prev;
    logic       step_up, step_dn, step_err;

    assign ready    = (ctrl_q == ST_RUN);
    assign rd_fire  = ready && host.rd_req && (rd_state_q == RD_IDLE);
    assign clr_fire = ready && host.clr_req;
    assign svc_cur  = {a_s2_q[scan_ch_q], b_s2_q[scan_ch_q]};
    assign svc_prev = last_q[scan_ch_q];

    // Transitions keyed as {previous ab, current ab}; forward order is 00,01,11,10.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        step_up  = 1'b0;
        step_dn  = 1'b0;
        step_err = 1'b0;
        case ({svc_prev, svc_cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_up  = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_dn  = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_err = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pos_d[i]  = pos_q[i];
            err_d[i]  = err_q[i];
            last_d[i] = last_q[i];
            if (scan_ch_q == CH_W'(i)) begin
                last_d[i] = svc_cur;
                if (ready) begin
                    if (step_up)       pos_d[i] = pos_q[i] + POS_W'(1);
                    else if (step_dn)  pos_d[i] = pos_q[i] - POS_W'(1);
                    if (step_err)      err_d[i] = 1'b1;
                end
            end
            // A clear overrides the decoder on the same channel, but last state still tracks.
            if (clr_fire && (host.clr_ch == CH_W'(i))) begin
                pos_d[i] = '0;
                err_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        scan_ch_d  = (scan_ch_q == CH_W'(NCH - 1)) ? '0 : scan_ch_q + CH_W'(1);
        ctrl_d     = ctrl_q;
        init_cnt_d = init_cnt_q;
        if (ctrl_q == ST_INIT) begin
            if (init_cnt_q == CNT_W'(NCH + 1)) ctrl_d = ST_RUN;
            else                               init_cnt_d = init_cnt_q + CNT_W'(1);
        end

        rd_state_d = rd_state_q;
        rd_pos_d   = rd_pos_q;
        rd_err_d   = rd_err_q;
        case (rd_state_q)
            RD_IDLE: if (rd_fire) begin
                rd_pos_d   = pos_q[host.rd_ch];
                rd_err_d   = err_q[host.rd_ch];
                rd_state_d = RD_ACK;
            end
            default: rd_state_d = RD_IDLE;
        endcase

        clr_ack_d = clr_fire;
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            a_s1_q     <= '0;
            a_s2_q     <= '0;
            b_s1_q     <= '0;
            b_s2_q     <= '0;
            scan_ch_q  <= '0;
            ctrl_q     <= ST_INIT;
            init_cnt_q <= '0;
            rd_state_q <= RD_IDLE;
            rd_pos_q   <= '0;
            rd_err_q   <= 1'b0;
            clr_ack_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values, which the synchronizer chain relies on.
            a_s1_q     <= enc_a_raw;
            a_s2_q     <= a_s1_q;
            b_s1_q     <= enc_b_raw;
            b_s2_q     <= b_s1_q;
            scan_ch_q  <= scan_ch_d;
            ctrl_q     <= ctrl_d;
            init_cnt_q <= init_cnt_d;
            rd_state_q <= rd_state_d;
            rd_pos_q   <= rd_pos_d;
            rd_err_q   <= rd_err_d;
            clr_ack_q  <= clr_ack_d;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            // NOTE: the per-channel table is flops, not RAM, so it is reset outright and no stale count survives.
            for (int i = 0; i < NCH; i++) begin
                pos_q[i]  <= '0;
                err_q[i]  <= 1'b0;
                last_q[i] <= 2'b00;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                pos_q[i]  <= pos_d[i];
                err_q[i]  <= err_d[i];
                last_q[i] <= last_d[i];
            end
        end
    end

    assign host.rd_ack  = (rd_state_q == RD_ACK);
    assign host.rd_pos  = rd_pos_q;
    assign host.rd_err  = rd_err_q;
    assign host.clr_ack = clr_ack_q;
    assign host.ready   = ready;
    assign host.scan_ch = scan_ch_q;
endmodule

// File: tb/tb_encoder_scanner.sv
// Scoreboard bench for encoder_scanner: the stimulus side walks encoder phases
// and queues expected reads; a negedge monitor compares every ack.
module tb_encoder_scanner;
    localparam int NCH   = 4;
    localparam int POS_W = 8;
    localparam int CH_W  = 2;
    localparam int MODV  = 1 << POS_W;

    typedef struct packed {
        logic [POS_W-1:0] pos;
        logic             err;
    } rd_exp_t;

    logic           sysclk = 1'b0;
    logic           reset  = 1'b1;
    logic [NCH-1:0] enc_a  = '0;
    logic [NCH-1:0] enc_b  = '0;

    encoder_scanner_if #(.NCH(NCH), .POS_W(POS_W)) bus ();

    encoder_scanner #(.NCH(NCH), .POS_W(POS_W)) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .enc_a_raw(enc_a),
        .enc_b_raw(enc_b),
        .host     (bus)
    );

    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: position as an integer, phase as an index into the forward cycle.
    logic [1:0] seq_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int         model_pos [NCH];
    bit         model_err [NCH];
    logic [1:0] model_st  [NCH];

    rd_exp_t rd_q [$];
    int      clr_pending = 0;
    int      rd_ack_cnt  = 0;
    int      clr_ack_cnt = 0;
    int      exp_scan    = 0;
    logic [POS_W-1:0] last_pos = '0;
    logic    last_err = 1'b0;
    logic    prev_ack = 1'b0;
    rd_exp_t e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [1:0] s);
        for (int i = 0; i < 4; i++) if (seq_tab[i] == s) return i;
        return 0;
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Apply a new phase to one channel, update the model, and let it settle.
    task automatic set_ch(input int ch, input logic [1:0] ns);
        int d;
        d = (idx_of(ns) - idx_of(model_st[ch]) + 4) % 4;
        if (d == 1)      model_pos[ch] = (model_pos[ch] + 1) % MODV;
        else if (d == 3) model_pos[ch] = (model_pos[ch] + MODV - 1) % MODV;
        else if (d == 2) model_err[ch] = 1'b1;
        model_st[ch] = ns;
        enc_a[ch] = ns[1];
        enc_b[ch] = ns[0];
        repeat (8) tick();
    endtask

    task automatic step(input int ch, input int dir);
        set_ch(ch, seq_tab[(idx_of(model_st[ch]) + dir + 4) % 4]);
    endtask

    task automatic issue(input bit rd, input int rch, input bit clr, input int cch);
        if (rd) rd_q.push_back(rd_exp_t'{pos: model_pos[rch][POS_W-1:0], err: model_err[rch]});
        if (clr) begin
            clr_pending++;
            model_pos[cch] = 0;
            model_err[cch] = 1'b0;
        end
        bus.rd_req  = rd;
        bus.rd_ch   = CH_W'(rch);
        bus.clr_req = clr;
        bus.clr_ch  = CH_W'(cch);
        tick();
        bus.rd_req  = 1'b0;
        bus.clr_req = 1'b0;
        if (rd)  check("rd_ack_timing", {31'd0, bus.rd_ack}, 1);
        if (clr) check("clr_ack_timing", {31'd0, bus.clr_ack}, 1);
        tick();
        if (rd)  check("rd_ack_width", {31'd0, bus.rd_ack}, 0);
        if (clr) check("clr_ack_width", {31'd0, bus.clr_ack}, 0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            model_pos[i] = 0;
            model_err[i] = 1'b0;
            model_st[i]  = {enc_a[i], enc_b[i]};
        end
    endtask

    task automatic init_sequence();
        for (int k = 1; k <= NCH + 2; k++) begin
            tick();
            check("ready_rise", {31'd0, bus.ready}, (k == NCH + 2) ? 1 : 0);
        end
    endtask

    always @(posedge sysclk) exp_scan <= reset ? 0 : (exp_scan + 1) % NCH;

    always @(negedge sysclk) begin
        if (reset) begin
            last_pos = '0;
            last_err = 1'b0;
            prev_ack = 1'b0;
        end else begin
            check("scan_ch", {30'd0, bus.scan_ch}, exp_scan);
            if (bus.rd_ack) begin
                rd_ack_cnt++;
                check("rd_ack_spacing", {31'd0, prev_ack}, 0);
                if (rd_q.size() == 0) begin
                    check("rd_ack_unexpected", {31'd0, bus.rd_ack}, 0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_pos", {24'd0, bus.rd_pos}, {24'd0, e.pos});
                    check("rd_err", {31'd0, bus.rd_err}, {31'd0, e.err});
                    last_pos = e.pos;
                    last_err = e.err;
                end
            end else begin
                check("rd_pos_hold", {24'd0, bus.rd_pos}, {24'd0, last_pos});
                check("rd_err_hold", {31'd0, bus.rd_err}, {31'd0, last_err});
            end
            if (bus.clr_ack) begin
                clr_ack_cnt++;
                if (clr_pending == 0) check("clr_ack_unexpected", {31'd0, bus.clr_ack}, 0);
                else clr_pending--;
            end
            prev_ack = bus.rd_ack;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        int ch;
        int r;
        bus.rd_req  = 1'b0;
        bus.rd_ch   = '0;
        bus.clr_req = 1'b0;
        bus.clr_ch  = '0;
        enc_a[1] = 1'b1;
        enc_b[1] = 1'b1;
        repeat (3) tick();

        check("rst_ready",   {31'd0, bus.ready}, 0);
        check("rst_rd_ack",  {31'd0, bus.rd_ack}, 0);
        check("rst_clr_ack", {31'd0, bus.clr_ack}, 0);
        check("rst_rd_pos",  {24'd0, bus.rd_pos}, 0);
        check("rst_rd_err",  {31'd0, bus.rd_err}, 0);
        check("rst_scan_ch", {30'd0, bus.scan_ch}, 0);

        // Release with ch1 at 11; requests during INIT must be ignored.
        model_reset();
        reset = 1'b0;
        bus.rd_req  = 1'b1;
        bus.rd_ch   = 2'd1;
        bus.clr_req = 1'b1;
        bus.clr_ch  = 2'd1;
        for (int k = 1; k <= NCH + 2; k++) begin
            tick();
            if (k == NCH + 1) begin
                bus.rd_req  = 1'b0;
                bus.clr_req = 1'b0;
            end
            check("ready_rise", {31'd0, bus.ready}, (k == NCH + 2) ? 1 : 0);
        end
        check("init_rd_acks",  rd_ack_cnt, 0);
        check("init_clr_acks", clr_ack_cnt, 0);
        issue(1, 1, 0, 0);

        // Full forward cycle then full reverse cycle on ch0.
        for (int i = 0; i < 4; i++) step(0, 1);
        issue(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, -1);
        issue(1, 0, 0, 0);

        // Wrap below zero and back up on ch2.
        step(2, -1);
        issue(1, 2, 0, 0);
        step(2, 1);
        step(2, 1);
        issue(1, 2, 0, 0);
        step(2, -1);
        step(2, -1);
        issue(1, 2, 0, 0);
        step(2, 1);
        issue(1, 2, 0, 0);

        // Double-bit jump on ch3 sets err; clear recovers it.
        step(3, 2);
        issue(1, 3, 0, 0);
        issue(0, 0, 1, 3);
        issue(1, 3, 0, 0);

        // Read and clear of ch0 in the same cycle returns the pre-clear count.
        for (int i = 0; i < 5; i++) step(0, 1);
        issue(1, 0, 1, 0);
        issue(1, 0, 0, 0);

        // Held read on ch1: acknowledged every second cycle.
        snap = rd_ack_cnt;
        for (int i = 0; i < 3; i++) rd_q.push_back(rd_exp_t'{pos: model_pos[1][POS_W-1:0], err: model_err[1]});
        bus.rd_req = 1'b1;
        bus.rd_ch  = 2'd1;
        repeat (6) tick();
        bus.rd_req = 1'b0;
        repeat (2) tick();
        check("held_read_acks", rd_ack_cnt - snap, 3);

        // Randomized walk over all channels with interleaved reads and clears.
        for (int n = 0; n < 150; n++) begin
            ch = $urandom_range(0, NCH - 1);
            r  = $urandom_range(0, 9);
            if (r < 4)       step(ch, 1);
            else if (r < 8)  step(ch, -1);
            else if (r == 8) step(ch, 2);
            else             step(ch, 0);
            if ($urandom_range(0, 1) == 1 || $urandom_range(0, 3) == 0)
                issue($urandom_range(0, 1), $urandom_range(0, NCH - 1),
                      ($urandom_range(0, 3) == 0), $urandom_range(0, NCH - 1));
        end

        // Reset right after a read and a clear are accepted: neither is acknowledged.
        bus.rd_req  = 1'b1;
        bus.rd_ch   = 2'd0;
        bus.clr_req = 1'b1;
        bus.clr_ch  = 2'd1;
        tick();
        reset = 1'b1;
        bus.rd_req  = 1'b0;
        bus.clr_req = 1'b0;
        #1;
        check("abort_rd_ack",  {31'd0, bus.rd_ack}, 0);
        check("abort_clr_ack", {31'd0, bus.clr_ack}, 0);
        check("abort_ready",   {31'd0, bus.ready}, 0);
        check("abort_rd_pos",  {24'd0, bus.rd_pos}, 0);
        check("abort_scan_ch", {30'd0, bus.scan_ch}, 0);
        repeat (2) tick();
        model_reset();
        reset = 1'b0;
        init_sequence();
        for (int i = 0; i < NCH; i++) issue(1, i, 0, 0);
        step(0, 1);
        step(0, 1);
        step(0, -1);
        issue(1, 0, 0, 0);

        for (int t = 0; t < 20 && (rd_q.size() != 0 || clr_pending != 0); t++) tick();
        check("rd_queue_drained",  rd_q.size(), 0);
        check("clr_queue_drained", clr_pending, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
